uart_share_arbiter: RTL and testbench

UART_SHARE_ARBITER -- requirements
Module: uart_share_arbiter

---
 rtl/uart_share_pkg.sv | 17 +
 rtl/uart_byte_buf.sv | 48 ++++
 rtl/uart_share_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_share_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_share_pkg.sv
// Shared types for the UART sharing arbiter: ownership state and the
// status encoding exported on o_mode.
package uart_share_pkg;

   localparam logic [1:0] MODE_IHEX   = 2'd0;
   localparam logic [1:0] MODE_DRAIN  = 2'd1;
   localparam logic [1:0] MODE_SLAVE  = 2'd2;
   localparam logic [1:0] MODE_RETURN = 2'd3;

   typedef enum logic [1:0] {
      S_IHEX   = MODE_IHEX,
      S_DRAIN  = MODE_DRAIN,
      S_SLAVE  = MODE_SLAVE,
      S_RETURN = MODE_RETURN
   } state_t;

endpackage

// File: rtl/uart_byte_buf.sv
// One-byte buffer with valid flag and a sticky collision flag. OVERWRITE
// selects whether a write into a full buffer replaces the byte or is dropped.
module uart_byte_buf #(
   parameter bit OVERWRITE = 1'b0
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_wr,
   input  logic [7:0] i_wr_data,
   input  logic       i_consume,
   input  logic       i_flag_clr,
   output logic       o_valid,
   output logic [7:0] o_data,
   output logic       o_flag
);

   logic accept;
   logic collide;

   // A consume in the same cycle frees the slot, so that write is not a collision.
   assign accept  = i_wr && (!o_valid || i_consume || OVERWRITE);
   assign collide = i_wr && o_valid && !i_consume;

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_valid <= 1'b0;
         // NOTE: the data byte is reset too because it drives a module output
         // directly; a pure storage array would not need it.
         o_data  <= 8'h00;
         o_flag  <= 1'b0;
      end else begin
         if (accept) begin
            o_data  <= i_wr_data;
            o_valid <= 1'b1;
         end else if (i_consume) begin
            o_valid <= 1'b0;
         end

         if (collide)
            o_flag <= 1'b1;
         else if (i_flag_clr)
            o_flag <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_share_arbiter.sv
// Shares one UART core between the ihex loader and a slave port; ownership
// moves to the slave only after the ihex side has been quiet for GUARD_CYCLES.
module uart_share_arbiter
   import uart_share_pkg::*;
#(
   parameter int GUARD_CYCLES = 16
) (
   input  logic       i_clk,
   input  logic       i_reset,
   // UART core side
   input  logic       i_rx_stb,
   input  logic [7:0] i_rx_data,
   output logic [7:0] o_tx_data,
   output logic       o_tx_stb,
   input  logic       i_tx_busy,
   // ihex side
   output logic       o_ihex_rx_stb,
   output logic [7:0] o_ihex_rx_data,
   input  logic       i_ihex_tx_stb,
   input  logic [7:0] i_ihex_tx_data,
   output logic       o_ihex_tx_busy,
   input  logic       i_ihex_idle,
   // slave side
   input  logic       i_sl_wr,
   input  logic [7:0] i_sl_wr_data,
   output logic       o_sl_tx_full,
   output logic       o_sl_rx_valid,
   output logic [7:0] o_sl_rx_data,
   input  logic       i_sl_rx_ack,
   output logic       o_sl_overrun,
   output logic       o_sl_drop,
   input  logic       i_sl_release,
   // status
   output logic [1:0] o_mode
);

   localparam int             CW         = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [CW-1:0]  GUARD_LAST = CW'(GUARD_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] guard_cnt;
   logic          tx_stb_q;
   logic          slave_mode;
   logic          guard_qual;
   logic          sl_fire;
   logic          ihex_fire;
   logic [7:0]    tx_hold;

   assign slave_mode = (state == S_SLAVE) || (state == S_RETURN);
   assign guard_qual = !i_tx_busy && i_ihex_idle && !i_ihex_tx_stb;

   // The UART raises busy one cycle after a strobe, so the previous strobe
   // blocks a new one and is reported to ihex as busy for that gap cycle.
   assign ihex_fire = !slave_mode && i_ihex_tx_stb && !i_tx_busy && !tx_stb_q;
   assign sl_fire   = slave_mode && o_sl_tx_full && !i_tx_busy && !tx_stb_q;

   assign o_tx_stb       = ihex_fire || sl_fire;
   assign o_tx_data      = slave_mode ? tx_hold : i_ihex_tx_data;
   assign o_ihex_tx_busy = slave_mode || i_tx_busy || tx_stb_q;

   assign o_ihex_rx_stb  = !slave_mode && i_rx_stb;
   assign o_ihex_rx_data = i_rx_data;

   assign o_mode = state;

   uart_byte_buf #(.OVERWRITE(1'b0)) u_tx_hold (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_wr       (i_sl_wr),
      .i_wr_data  (i_sl_wr_data),
      .i_consume  (sl_fire),
      .i_flag_clr (i_sl_release),
      .o_valid    (o_sl_tx_full),
      .o_data     (tx_hold),
      .o_flag     (o_sl_drop)
   );

   uart_byte_buf #(.OVERWRITE(1'b1)) u_rx_buf (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_wr       (i_rx_stb && slave_mode),
      .i_wr_data  (i_rx_data),
      .i_consume  (i_sl_rx_ack),
      .i_flag_clr (i_sl_release),
      .o_valid    (o_sl_rx_valid),
      .o_data     (o_sl_rx_data),
      .o_flag     (o_sl_overrun)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= S_IHEX;
         guard_cnt <= '0;
         tx_stb_q  <= 1'b0;
      end else begin
         tx_stb_q  <= o_tx_stb;
         guard_cnt <= '0;
         case (state)
            S_IHEX: begin
               if (i_sl_wr)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               // Any non-quiet cycle restarts the guard window from zero.
               if (guard_qual) begin
                  if (guard_cnt == GUARD_LAST)
                     state <= S_SLAVE;
                  else
                     guard_cnt <= guard_cnt + CW'(1);
               end
            end
            S_SLAVE: begin
               if (i_sl_release)
                  state <= S_RETURN;
            end
            S_RETURN: begin
               if (!o_sl_tx_full && !i_tx_busy && !tx_stb_q)
                  state <= S_IHEX;
            end
            default: state <= S_IHEX;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_share_arbiter.sv
// Directed bench for uart_share_arbiter: a vector table for the ihex
// pass-through paths plus hand-written sequences for the ownership handover.
module tb_uart_share_arbiter;
   import uart_share_pkg::*;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_rx_stb;
   logic [7:0] i_rx_data;
   logic [7:0] o_tx_data;
   logic       o_tx_stb;
   logic       i_tx_busy;
   logic       o_ihex_rx_stb;
   logic [7:0] o_ihex_rx_data;
   logic       i_ihex_tx_stb;
   logic [7:0] i_ihex_tx_data;
   logic       o_ihex_tx_busy;
   logic       i_ihex_idle;
   logic       i_sl_wr;
   logic [7:0] i_sl_wr_data;
   logic       o_sl_tx_full;
   logic       o_sl_rx_valid;
   logic [7:0] o_sl_rx_data;
   logic       i_sl_rx_ack;
   logic       o_sl_overrun;
   logic       o_sl_drop;
   logic       i_sl_release;
   logic [1:0] o_mode;

   int checks = 0;
   int errors = 0;

   uart_share_arbiter #(.GUARD_CYCLES(16)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_rx_stb       (i_rx_stb),
      .i_rx_data      (i_rx_data),
      .o_tx_data      (o_tx_data),
      .o_tx_stb       (o_tx_stb),
      .i_tx_busy      (i_tx_busy),
      .o_ihex_rx_stb  (o_ihex_rx_stb),
      .o_ihex_rx_data (o_ihex_rx_data),
      .i_ihex_tx_stb  (i_ihex_tx_stb),
      .i_ihex_tx_data (i_ihex_tx_data),
      .o_ihex_tx_busy (o_ihex_tx_busy),
      .i_ihex_idle    (i_ihex_idle),
      .i_sl_wr        (i_sl_wr),
      .i_sl_wr_data   (i_sl_wr_data),
      .o_sl_tx_full   (o_sl_tx_full),
      .o_sl_rx_valid  (o_sl_rx_valid),
      .o_sl_rx_data   (o_sl_rx_data),
      .i_sl_rx_ack    (i_sl_rx_ack),
      .o_sl_overrun   (o_sl_overrun),
      .o_sl_drop      (o_sl_drop),
      .i_sl_release   (i_sl_release),
      .o_mode         (o_mode)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic       ihex_stb;
      logic [7:0] ihex_data;
      logic       busy;
      logic       rx_stb;
      logic [7:0] rx_data;
      logic       e_tx_stb;
      logic [7:0] e_tx_data;
      logic       e_ihex_busy;
      logic       e_ihex_rx_stb;
      logic [7:0] e_ihex_rx_data;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; registered outputs are stable then.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      int n;
      int stb_cnt;
      logic [7:0] sent;

      vecs[0] = '{1'b1, 8'h3A, 1'b0, 1'b0, 8'h00, 1'b1, 8'h3A, 1'b0, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 8'hC5, 1'b1, 1'b0, 8'h00, 1'b0, 8'hC5, 1'b1, 1'b0, 8'h00};
      vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5};
      vecs[3] = '{1'b1, 8'h0F, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h0F, 1'b0, 1'b1, 8'h5A};
      vecs[4] = '{1'b0, 8'h12, 1'b1, 1'b0, 8'h77, 1'b0, 8'h12, 1'b1, 1'b0, 8'h77};

      i_reset = 1'b1;
      i_rx_stb = 1'b0;      i_rx_data = 8'h00;
      i_tx_busy = 1'b0;     i_ihex_tx_stb = 1'b0;  i_ihex_tx_data = 8'h00;
      i_ihex_idle = 1'b0;   i_sl_wr = 1'b0;        i_sl_wr_data = 8'h00;
      i_sl_rx_ack = 1'b0;   i_sl_release = 1'b0;
      repeat (3) tick();
      i_reset = 1'b0;
      settle();
      check("reset_mode", o_mode, MODE_IHEX);
      check("reset_tx_full", o_sl_tx_full, 0);
      check("reset_rx_valid", o_sl_rx_valid, 0);
      check("reset_overrun", o_sl_overrun, 0);
      check("reset_drop", o_sl_drop, 0);
      check("reset_tx_stb", o_tx_stb, 0);

      // ihex-owned pass-through vectors, each followed by a quiet cycle
      foreach (vecs[i]) begin
         i_ihex_tx_stb = vecs[i].ihex_stb;  i_ihex_tx_data = vecs[i].ihex_data;
         i_tx_busy     = vecs[i].busy;
         i_rx_stb      = vecs[i].rx_stb;    i_rx_data      = vecs[i].rx_data;
         settle();
         check($sformatf("vec%0d_tx_stb", i), o_tx_stb, vecs[i].e_tx_stb);
         check($sformatf("vec%0d_tx_data", i), o_tx_data, vecs[i].e_tx_data);
         check($sformatf("vec%0d_ihex_busy", i), o_ihex_tx_busy, vecs[i].e_ihex_busy);
         check($sformatf("vec%0d_ihex_rx_stb", i), o_ihex_rx_stb, vecs[i].e_ihex_rx_stb);
         check($sformatf("vec%0d_ihex_rx_data", i), o_ihex_rx_data, vecs[i].e_ihex_rx_data);
         check($sformatf("vec%0d_mode", i), o_mode, MODE_IHEX);
         tick();
         i_ihex_tx_stb = 1'b0; i_tx_busy = 1'b0; i_rx_stb = 1'b0;
         tick();
      end

      // Back-to-back ihex requests: the second cycle must not strobe
      i_ihex_tx_stb = 1'b1; i_ihex_tx_data = 8'h41;
      settle();
      check("b2b_first_stb", o_tx_stb, 1);
      tick();
      settle();
      check("b2b_second_stb", o_tx_stb, 0);
      i_ihex_tx_stb = 1'b0;
      tick();

      // Handover: slave write, 16 quiet cycles in drain, then the byte goes out
      i_ihex_idle = 1'b1;
      i_sl_wr = 1'b1; i_sl_wr_data = 8'h55;
      tick();
      i_sl_wr = 1'b0;
      settle();
      check("drain_tx_full", o_sl_tx_full, 1);
      n = 0;
      while (o_mode == MODE_DRAIN && n < 40) begin
         n++;
         tick();
      end
      check("drain_cycles", n, 16);
      settle();
      check("slave_mode", o_mode, MODE_SLAVE);
      check("slave_first_stb", o_tx_stb, 1);
      check("slave_first_data", o_tx_data, 8'h55);
      check("slave_ihex_busy", o_ihex_tx_busy, 1);
      tick();
      check("slave_hold_emptied", o_sl_tx_full, 0);
      check("slave_no_repeat_stb", o_tx_stb, 0);

      // Slave RX: two unacked bytes overwrite and flag overrun
      i_rx_stb = 1'b1; i_rx_data = 8'h11;
      settle();
      check("rx1_ihex_stb", o_ihex_rx_stb, 0);
      tick();
      i_rx_data = 8'h22;
      settle();
      check("rx2_ihex_stb", o_ihex_rx_stb, 0);
      check("rx1_data", o_sl_rx_data, 8'h11);
      check("rx1_overrun", o_sl_overrun, 0);
      tick();
      i_rx_stb = 1'b0;
      check("rx2_data", o_sl_rx_data, 8'h22);
      check("rx2_valid", o_sl_rx_valid, 1);
      check("rx2_overrun", o_sl_overrun, 1);
      i_sl_rx_ack = 1'b1;
      tick();
      i_sl_rx_ack = 1'b0;
      check("rx_ack_clears", o_sl_rx_valid, 0);
      check("rx_overrun_sticky", o_sl_overrun, 1);
      i_rx_stb = 1'b1; i_rx_data = 8'h44;
      tick();
      i_rx_data = 8'h66; i_sl_rx_ack = 1'b1;
      tick();
      i_rx_stb = 1'b0; i_sl_rx_ack = 1'b0;
      check("rx_ack_race_valid", o_sl_rx_valid, 1);
      check("rx_ack_race_data", o_sl_rx_data, 8'h66);
      i_sl_rx_ack = 1'b1;
      tick();
      i_sl_rx_ack = 1'b0;

      // Two writes while busy: second dropped, first sent once busy falls
      i_tx_busy = 1'b1;
      i_sl_wr = 1'b1; i_sl_wr_data = 8'hA0;
      tick();
      i_sl_wr_data = 8'hA1;
      tick();
      i_sl_wr = 1'b0;
      check("drop_flag", o_sl_drop, 1);
      check("drop_tx_full", o_sl_tx_full, 1);
      stb_cnt = 0; sent = 8'h00;
      for (int i = 0; i < 3; i++) begin
         settle();
         if (o_tx_stb) stb_cnt++;
         tick();
      end
      i_tx_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         settle();
         if (o_tx_stb) begin
            stb_cnt++;
            sent = o_tx_data;
         end
         tick();
      end
      check("drop_stb_count", stb_cnt, 1);
      check("drop_sent_byte", sent, 8'hA0);

      // Release together with a final write: byte goes out during return
      i_sl_release = 1'b1; i_sl_wr = 1'b1; i_sl_wr_data = 8'h7E;
      tick();
      i_sl_release = 1'b0; i_sl_wr = 1'b0;
      settle();
      check("ret_mode", o_mode, MODE_RETURN);
      check("ret_stb", o_tx_stb, 1);
      check("ret_data", o_tx_data, 8'h7E);
      check("ret_drop_cleared", o_sl_drop, 0);
      check("ret_overrun_cleared", o_sl_overrun, 0);
      tick();
      i_tx_busy = 1'b1;
      repeat (4) tick();
      check("ret_held_while_busy", o_mode, MODE_RETURN);
      i_tx_busy = 1'b0;
      settle();
      check("ret_still_before_edge", o_mode, MODE_RETURN);
      tick();
      check("ret_handback", o_mode, MODE_IHEX);

      // Guard restart: busy pulse in drain cycle 10 stretches drain to 26 cycles
      i_sl_wr = 1'b1; i_sl_wr_data = 8'h99;
      tick();
      i_sl_wr = 1'b0;
      n = 0;
      while (o_mode == MODE_DRAIN && n < 60) begin
         n++;
         i_tx_busy = (n == 10);
         tick();
      end
      i_tx_busy = 1'b0;
      check("guard_restart_cycles", n, 26);
      settle();
      check("guard_slave_stb", o_tx_stb, 1);
      check("guard_slave_data", o_tx_data, 8'h99);
      tick();

      // Reset mid-slave with full holding register, pending RX and drop flag
      i_tx_busy = 1'b1;
      i_sl_wr = 1'b1; i_sl_wr_data = 8'hBB;
      i_rx_stb = 1'b1; i_rx_data = 8'hCC;
      tick();
      i_sl_wr_data = 8'hBC; i_rx_stb = 1'b0;
      tick();
      i_sl_wr = 1'b0;
      check("pre_reset_mode", o_mode, MODE_SLAVE);
      check("pre_reset_full", o_sl_tx_full, 1);
      check("pre_reset_drop", o_sl_drop, 1);
      i_reset = 1'b1; i_tx_busy = 1'b0;
      tick();
      i_reset = 1'b0;
      settle();
      check("post_reset_mode", o_mode, MODE_IHEX);
      check("post_reset_full", o_sl_tx_full, 0);
      check("post_reset_stb", o_tx_stb, 0);
      check("post_reset_rx_valid", o_sl_rx_valid, 0);
      check("post_reset_drop", o_sl_drop, 0);
      tick();
      check("post_reset_stb_next", o_tx_stb, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
